// File: rtl/seq_mult_32bit_if.sv
// Operation handshake (start/busy/done) and operand/product bus for seq_mult_32bit.
// Macro MULT_OVF_EN adds the ovf result flag.
interface seq_mult_32bit_if #(
    parameter int WIDTH = 32
);
    logic                   start;
    logic                   signed_op;
    logic [WIDTH-1:0]       a;
    logic [WIDTH-1:0]       b;
    logic                   busy;
    logic                   done;
    logic [2*WIDTH-1:0]     product;

`ifdef MULT_OVF_EN
    logic                   ovf;

    modport master (
        output start, signed_op, a, b,
        input  busy, done, product, ovf
    );

    modport slave (
        input  start, signed_op, a, b,
        output busy, done, product, ovf
    );
`else
    modport master (
        output start, signed_op, a, b,
        input  busy, done, product
    );

    modport slave (
        input  start, signed_op, a, b,
        output busy, done, product
    );
`endif
endinterface

// File: rtl/seq_mult_32bit.sv
// Shift-add WIDTHxWIDTH multiplier: start->done in WIDTH+3 cycles, start ignored while busy.
// Macro MULT_OVF_EN adds a registered ovf flag alongside product.
module seq_mult_32bit #(
    parameter int WIDTH = 32
) (
    input  logic          clk,
    input  logic          reset,
    seq_mult_32bit_if.slave bus
);
    localparam int                 CW    = $clog2(WIDTH);
    localparam logic [CW-1:0]      LAST  = CW'(WIDTH - 1);
    localparam logic [WIDTH-1:0]   ONE_W = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [2*WIDTH-1:0] ONE_P = {{(2*WIDTH-1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        IDLE,
        PREP,
        RUN,
        FIX,
        DONE
    } state_t;

    state_t               state;
    state_t               state_nxt;
    logic                 busy;
    logic                 done;

    logic [WIDTH-1:0]     op_a;
    logic [WIDTH-1:0]     op_b;
    logic                 signed_q;
    logic                 neg_res;
    logic [WIDTH-1:0]     mag_a;
    logic [2*WIDTH-1:0]   sr;
    logic [CW-1:0]        counter;
    logic [2*WIDTH-1:0]   product_q;

    logic [WIDTH-1:0]     mag_a_nxt;
    logic [WIDTH-1:0]     mag_b_nxt;
    logic [WIDTH-1:0]     addend;
    logic [WIDTH:0]       sum;
    logic [2*WIDTH-1:0]   result;

`ifdef MULT_OVF_EN
    logic                 ovf_q;
    logic                 ovf_nxt;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start) state_nxt = PREP;
            end
            PREP: begin
                busy      = 1'b1;
                state_nxt = RUN;
            end
            RUN: begin
                busy = 1'b1;
                if (counter == LAST) state_nxt = FIX;
            end
            FIX: begin
                busy      = 1'b1;
                state_nxt = DONE;
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = bus.start ? PREP : IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Negation is invert-plus-one; the most-negative operand maps to 2^(WIDTH-1) as unsigned.
    always_comb begin
        mag_a_nxt = (signed_q && op_a[WIDTH-1]) ? (~op_a + ONE_W) : op_a;
        mag_b_nxt = (signed_q && op_b[WIDTH-1]) ? (~op_b + ONE_W) : op_b;
        addend    = sr[0] ? mag_a : '0;
        sum       = {1'b0, sr[2*WIDTH-1:WIDTH]} + {1'b0, addend};
        result    = neg_res ? (~sr + ONE_P) : sr;
`ifdef MULT_OVF_EN
        if (signed_q) begin
            ovf_nxt = ~((&result[2*WIDTH-1:WIDTH-1]) | ~(|result[2*WIDTH-1:WIDTH-1]));
        end else begin
            ovf_nxt = |result[2*WIDTH-1:WIDTH];
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            op_a      <= '0;
            op_b      <= '0;
            signed_q  <= 1'b0;
            neg_res   <= 1'b0;
            mag_a     <= '0;
            sr        <= '0;
            counter   <= '0;
            product_q <= '0;
`ifdef MULT_OVF_EN
            ovf_q     <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (bus.start) begin
                        op_a     <= bus.a;
                        op_b     <= bus.b;
                        signed_q <= bus.signed_op;
                        neg_res  <= bus.signed_op & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
                    end
                end
                PREP: begin
                    mag_a   <= mag_a_nxt;
                    sr      <= {{WIDTH{1'b0}}, mag_b_nxt};
                    counter <= '0;
                end
                // Upper half accumulates; the carry-out re-enters at the MSB on the shift.
                RUN: begin
                    sr      <= {sum, sr[WIDTH-1:1]};
                    counter <= counter + 1'b1;
                end
                FIX: begin
                    product_q <= result;
`ifdef MULT_OVF_EN
                    ovf_q     <= ovf_nxt;
`endif
                end
                default: ;
            endcase
        end
    end

    assign bus.busy    = busy;
    assign bus.done    = done;
    assign bus.product = product_q;
`ifdef MULT_OVF_EN
    assign bus.ovf     = ovf_q;
`endif
endmodule
